// File: rtl/cpu_run_ctrl_if.sv
// Signal bundle between the program-load/run sequencer and its surroundings
// (UART receiver, run switch, CPU core).
interface cpu_run_ctrl_if #(
    parameter int ADDR_W = 8
);
    logic              i_run_btn;
    logic              i_rx_dv;
    logic [15:0]       i_rx_instr;
    logic              i_loopf;
    logic [ADDR_W-1:0] o_instr_addr;
    logic [15:0]       o_instr;
    logic              o_we;
    logic              o_cpu_on;
    logic              o_cpu_rst;
    logic [ADDR_W:0]   o_prog_len;
    logic              o_done;
    logic              o_fault;
    logic              o_overflow;

    modport slave (
        input  i_run_btn, i_rx_dv, i_rx_instr, i_loopf,
        output o_instr_addr, o_instr, o_we, o_cpu_on, o_cpu_rst,
               o_prog_len, o_done, o_fault, o_overflow
    );

    modport master (
        output i_run_btn, i_rx_dv, i_rx_instr, i_loopf,
        input  o_instr_addr, o_instr, o_we, o_cpu_on, o_cpu_rst,
               o_prog_len, o_done, o_fault, o_overflow
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// FRANK6000 program-load and run sequencer: loads UART words into instruction
// memory, gates execution with the run switch, detects completion and runaway.
//
// state   | meaning
// S_LOAD  | accept instruction words, wait for a run request
// S_RUN   | CPU executing, watchdog counting down
// S_DONE  | CPU reported loop/finish, result held
// S_FAULT | watchdog expired, CPU halted
module cpu_run_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 25_000_000
) (
    input logic            i_clk,
    input logic            i_rst,
    cpu_run_ctrl_if.slave  bus
);
    localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [WD_W-1:0] WD_LOAD = (TIMEOUT > 1) ? WD_W'(TIMEOUT - 1) : '0;

    typedef enum logic [1:0] {S_LOAD, S_RUN, S_DONE, S_FAULT} state_t;

    state_t state;
    state_t state_nxt;

    logic              btn_prev;
    logic              btn_evt;
    logic              wr_full;
    logic              wr_ok;
    logic              wd_expired;
    logic [ADDR_W:0]   wr_addr;
    logic [ADDR_W:0]   prog_len;
    logic [WD_W-1:0]   wd_cnt;

    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [15:0]       instr_q;
    logic              cpu_on_q;
    logic              cpu_rst_q;
    logic              done_q;
    logic              fault_q;
    logic              ovf_q;

    logic              enter_load;
    logic              cpu_on_nxt;
    logic              cpu_rst_nxt;
    logic              done_nxt;
    logic              fault_nxt;

    assign btn_evt    = btn_prev & ~bus.i_run_btn;
    assign wr_full    = wr_addr[ADDR_W];
    assign wr_ok      = (state == S_LOAD) && bus.i_rx_dv && !wr_full;
    assign wd_expired = (TIMEOUT != 0) && (wd_cnt == '0);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // A write landing in the same cycle as the run request counts toward the program.
    always_comb begin
        state_nxt = state;
        case (state)
            S_LOAD: begin
                if (btn_evt && ((prog_len != '0) || wr_ok)) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (btn_evt) begin
                    state_nxt = S_LOAD;
                end else if (bus.i_loopf) begin
                    state_nxt = S_DONE;
                end else if (wd_expired) begin
                    state_nxt = S_FAULT;
                end
            end
            S_DONE, S_FAULT: begin
                if (btn_evt) begin
                    state_nxt = S_LOAD;
                end
            end
            default: state_nxt = S_LOAD;
        endcase
    end

    always_comb begin
        enter_load  = (state != S_LOAD) && (state_nxt == S_LOAD);
        cpu_on_nxt  = (state_nxt == S_RUN) || (state_nxt == S_DONE);
        cpu_rst_nxt = (state == S_LOAD) && (state_nxt == S_RUN);
        done_nxt    = (state_nxt == S_DONE);
        fault_nxt   = (state_nxt == S_FAULT);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            btn_prev  <= 1'b0;
            wr_addr   <= '0;
            prog_len  <= '0;
            wd_cnt    <= '0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            instr_q   <= '0;
            cpu_on_q  <= 1'b0;
            cpu_rst_q <= 1'b0;
            done_q    <= 1'b0;
            fault_q   <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            btn_prev  <= bus.i_run_btn;
            we_q      <= wr_ok;
            cpu_on_q  <= cpu_on_nxt;
            cpu_rst_q <= cpu_rst_nxt;
            done_q    <= done_nxt;
            fault_q   <= fault_nxt;

            if (wr_ok) begin
                addr_q   <= wr_addr[ADDR_W-1:0];
                instr_q  <= bus.i_rx_instr;
                wr_addr  <= wr_addr + 1'b1;
                prog_len <= wr_addr + 1'b1;
            end else if (enter_load) begin
                wr_addr <= '0;
            end

            if (enter_load) begin
                ovf_q <= 1'b0;
            end else if ((state == S_LOAD) && bus.i_rx_dv && wr_full) begin
                ovf_q <= 1'b1;
            end

            // Down-counter reaches zero on the last permitted RUN cycle.
            if (cpu_rst_nxt) begin
                wd_cnt <= WD_LOAD;
            end else if ((state == S_RUN) && (wd_cnt != '0)) begin
                wd_cnt <= wd_cnt - 1'b1;
            end
        end
    end

    assign bus.o_we         = we_q;
    assign bus.o_instr_addr = addr_q;
    assign bus.o_instr      = instr_q;
    assign bus.o_cpu_on     = cpu_on_q;
    assign bus.o_cpu_rst    = cpu_rst_q;
    assign bus.o_prog_len   = prog_len;
    assign bus.o_done       = done_q;
    assign bus.o_fault      = fault_q;
    assign bus.o_overflow   = ovf_q;
endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Drives two sequencer instances (small memory with watchdog, watchdog off) from
// shared stimulus and compares both against a cycle model of the sequencing rules.
module tb_cpu_run_ctrl;
    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        btn;
    logic        dv;
    logic        loopf;
    logic [15:0] word;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    cpu_run_ctrl_if #(.ADDR_W(2)) ifa ();
    cpu_run_ctrl_if #(.ADDR_W(3)) ifb ();

    assign ifa.i_run_btn  = btn;
    assign ifa.i_rx_dv    = dv;
    assign ifa.i_rx_instr = word;
    assign ifa.i_loopf    = loopf;
    assign ifb.i_run_btn  = btn;
    assign ifb.i_rx_dv    = dv;
    assign ifb.i_rx_instr = word;
    assign ifb.i_loopf    = loopf;

    cpu_run_ctrl #(.ADDR_W(2), .TIMEOUT(10)) dut_a (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (ifa)
    );

    cpu_run_ctrl #(.ADDR_W(3), .TIMEOUT(0)) dut_b (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (ifb)
    );

    // phase: 0 load, 1 run, 2 done, 3 fault; run_cycles counts RUN cycles elapsed
    typedef struct packed {
        int phase;
        int wr_addr;
        int prog_len;
        int ovf;
        int run_cycles;
        int btn_prev;
        int we;
        int addr;
        int instr;
        int cpu_rst;
    } mdl_t;

    mdl_t ma;
    mdl_t mb;
    logic [15:0] mem_a [4];

    function automatic mdl_t step(mdl_t m, int aw, int tmo, logic rst, logic b,
                                  logic v, logic [15:0] w, logic lf);
        mdl_t n;
        bit   evt;
        bit   to_load;
        n = m;
        if (rst) begin
            n = '0;
            return n;
        end
        evt        = (m.btn_prev != 0) && !b;
        to_load    = 1'b0;
        n.btn_prev = int'(b);
        n.we       = 0;
        n.cpu_rst  = 0;
        case (m.phase)
            0: begin
                if (v) begin
                    if (m.wr_addr < (1 << aw)) begin
                        n.we       = 1;
                        n.addr     = m.wr_addr;
                        n.instr    = int'(w);
                        n.wr_addr  = m.wr_addr + 1;
                        n.prog_len = m.wr_addr + 1;
                    end else begin
                        n.ovf = 1;
                    end
                end
                if (evt && n.prog_len > 0) begin
                    n.phase      = 1;
                    n.cpu_rst    = 1;
                    n.run_cycles = 0;
                end
            end
            1: begin
                n.run_cycles = m.run_cycles + 1;
                if (evt) to_load = 1'b1;
                else if (lf) n.phase = 2;
                else if (tmo != 0 && m.run_cycles + 1 == tmo) n.phase = 3;
            end
            default: begin
                if (evt) to_load = 1'b1;
            end
        endcase
        if (to_load) begin
            n.phase   = 0;
            n.wr_addr = 0;
            n.ovf     = 0;
        end
        return n;
    endfunction

    task automatic check(string tag, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic cmp(string p, logic we, logic [31:0] addr, logic [15:0] ins,
                       logic on, logic crst, logic [31:0] len, logic dn,
                       logic flt, logic ovf, mdl_t m);
        check({p, ".we"}, 32'(we), m.we);
        if (m.we != 0) begin
            check({p, ".addr"}, addr, m.addr);
            check({p, ".instr"}, 32'(ins), m.instr);
        end
        check({p, ".cpu_on"}, 32'(on), 32'(m.phase == 1 || m.phase == 2));
        check({p, ".cpu_rst"}, 32'(crst), m.cpu_rst);
        check({p, ".prog_len"}, len, m.prog_len);
        check({p, ".done"}, 32'(dn), 32'(m.phase == 2));
        check({p, ".fault"}, 32'(flt), 32'(m.phase == 3));
        check({p, ".overflow"}, 32'(ovf), m.ovf);
    endtask

    task automatic tick();
        @(posedge i_clk);
        ma = step(ma, 2, 10, i_rst, btn, dv, word, loopf);
        mb = step(mb, 3, 0, i_rst, btn, dv, word, loopf);
        #1;
        if (ifa.o_we) mem_a[ifa.o_instr_addr] = ifa.o_instr;
        cmp("a", ifa.o_we, 32'(ifa.o_instr_addr), ifa.o_instr, ifa.o_cpu_on,
            ifa.o_cpu_rst, 32'(ifa.o_prog_len), ifa.o_done, ifa.o_fault,
            ifa.o_overflow, ma);
        cmp("b", ifb.o_we, 32'(ifb.o_instr_addr), ifb.o_instr, ifb.o_cpu_on,
            ifb.o_cpu_rst, 32'(ifb.o_prog_len), ifb.o_done, ifb.o_fault,
            ifb.o_overflow, mb);
    endtask

    // Returns right after the edge that samples the release.
    task automatic press_release();
        btn = 1'b1;
        tick();
        tick();
        btn = 1'b0;
        tick();
    endtask

    initial begin
        int n;
        int flt_b;
        int loop_div;
        ma = '0;
        mb = '0;
        foreach (mem_a[i]) mem_a[i] = '0;
        i_rst = 1'b1;
        btn   = 1'b0;
        dv    = 1'b0;
        loopf = 1'b0;
        word  = '0;
        repeat (3) tick();
        check("rst_cpu_on", 32'(ifa.o_cpu_on), 0);
        check("rst_prog_len", 32'(ifa.o_prog_len), 0);
        check("rst_addr", 32'(ifa.o_instr_addr), 0);
        check("rst_instr", 32'(ifa.o_instr), 0);
        i_rst = 1'b0;
        tick();

        press_release();
        check("empty_cpu_on", 32'(ifa.o_cpu_on), 0);
        check("empty_cpu_rst", 32'(ifa.o_cpu_rst), 0);

        dv = 1'b1;
        word = 16'h1234; tick();
        word = 16'hABCD; tick();
        word = 16'h0001; tick();
        dv = 1'b0;
        tick();
        check("load_mem0", 32'(mem_a[0]), 32'h1234);
        check("load_mem1", 32'(mem_a[1]), 32'hABCD);
        check("load_mem2", 32'(mem_a[2]), 32'h0001);
        check("load_len", 32'(ifa.o_prog_len), 3);

        press_release();
        check("run_cpu_on", 32'(ifa.o_cpu_on), 1);
        check("run_cpu_rst", 32'(ifa.o_cpu_rst), 1);
        tick();
        check("run_rst_1cyc", 32'(ifa.o_cpu_rst), 0);
        loopf = 1'b1;
        tick();
        loopf = 1'b0;
        check("done_flag", 32'(ifa.o_done), 1);
        check("done_cpu_on", 32'(ifa.o_cpu_on), 1);

        press_release();
        check("back_load_on", 32'(ifa.o_cpu_on), 0);
        check("back_load_len", 32'(ifa.o_prog_len), 3);
        press_release();
        check("rerun_cpu_rst", 32'(ifa.o_cpu_rst), 1);
        repeat (2) tick();
        press_release();
        check("abort_cpu_on", 32'(ifa.o_cpu_on), 0);

        dv = 1'b1;
        for (int i = 0; i < 5; i++) begin
            word = 16'($urandom);
            tick();
        end
        dv = 1'b0;
        tick();
        check("ovf_flag", 32'(ifa.o_overflow), 1);
        check("ovf_len", 32'(ifa.o_prog_len), 4);
        check("ovf_b_len", 32'(ifb.o_prog_len), 5);
        press_release();
        press_release();
        check("ovf_cleared", 32'(ifa.o_overflow), 0);

        press_release();
        n = 0;
        while (!ifa.o_fault && n < 40) begin
            tick();
            n++;
        end
        check("wd_cycles", n, 10);
        check("wd_cpu_on", 32'(ifa.o_cpu_on), 0);
        flt_b = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (ifb.o_fault) flt_b++;
        end
        check("wd_off_faults", flt_b, 0);
        check("wd_off_cpu_on", 32'(ifb.o_cpu_on), 1);
        press_release();

        btn = 1'b1;
        tick();
        tick();
        btn  = 1'b0;
        dv   = 1'b1;
        word = 16'hBEEF;
        tick();
        dv = 1'b0;
        check("coll_we", 32'(ifa.o_we), 1);
        check("coll_addr", 32'(ifa.o_instr_addr), 0);
        check("coll_cpu_rst", 32'(ifa.o_cpu_rst), 1);
        check("coll_len", 32'(ifa.o_prog_len), 1);
        dv = 1'b1;
        tick();
        dv = 1'b0;
        check("run_dv_we", 32'(ifa.o_we), 0);
        btn = 1'b1;
        tick();
        tick();
        btn   = 1'b0;
        loopf = 1'b1;
        tick();
        loopf = 1'b0;
        check("loopf_btn_on", 32'(ifa.o_cpu_on), 0);
        check("loopf_btn_done", 32'(ifa.o_done), 0);

        press_release();
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrun_rst_on", 32'(ifa.o_cpu_on), 0);
        check("midrun_rst_len", 32'(ifa.o_prog_len), 0);

        loop_div = 3;
        for (int c = 0; c < 4000; c++) begin
            if (c % 500 == 0) loop_div = (c / 500) % 3 == 0 ? 3 : ((c / 500) % 3 == 1 ? 15 : 60);
            if ($urandom_range(0, 7) == 0) btn = ~btn;
            dv    = ($urandom_range(0, 2) == 0);
            word  = 16'($urandom);
            loopf = ($urandom_range(0, loop_div) == 0);
            i_rst = ($urandom_range(0, 599) == 0);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
